sram22_param_sram: RTL and testbench
====================================

Name: sram22_param_sram

Overview:
Parametrised behavioural model of the sram22 single-port macro family. It generalises word width, depth and write-mask granularity, and adds an optional output pipeline register with a read-valid strobe. It also adds optional write-through and a post-reset clear sequencer that zeroes the array before accepting accesses. It is instantiated wherever a generated sram22 macro is simulated or used as an FPGA/RTL stand-in.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of WMASK_WIDTH
ADDR_WIDTH, 6, address bits; RAM_DEPTH = 2**ADDR_WIDTH
WMASK_WIDTH, 4, write-mask lanes; lane width MASK_GRAN = DATA_WIDTH/WMASK_WIDTH
OUT_REG, 0, 0 gives a 1-cycle read latency; 1 adds a second output register for a 2-cycle latency
WRITE_THROUGH, 0, 1 makes an accepted write also return the merged post-write word on dout
CLEAR_ON_RESET, 1, 1 zeroes the whole array after reset before the block accepts accesses

Ports:
clk  input  1  clock; all state updates on the rising edge
rstb  input  1  reset bar; asynchronous, active-low
ce  input  1  chip enable; an access is accepted when ce=1 and busy=0
we  input  1  1 = write, 0 = read
wmask  input  WMASK_WIDTH  per-lane write enable; bit i covers din[i*MASK_GRAN +: MASK_GRAN]
addr  input  ADDR_WIDTH  word address
din  input  DATA_WIDTH  write data
dout  output  DATA_WIDTH  read data; holds its value between reads
rvalid  output  1  one-cycle pulse, coincident with new dout data
busy  output  1  clear sequencer active; accesses are ignored while high
(With USE_POWER_PINS defined, inout ports vdd and vss precede clk, as on every sram22 macro.)

Behaviour:
- Reset (rstb=0, asynchronous):
  - dout=0, rvalid=0, all pipeline stages cleared.
  - busy=CLEAR_ON_RESET; clear counter=0; FSM goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - Array contents are not reset asynchronously.
- FSM states:
  - CLEAR: each cycle writes mem[cnt]=0 and increments cnt. After writing RAM_DEPTH-1 it goes to IDLE; busy falls in the same edge.
  - busy is therefore high for exactly RAM_DEPTH rising edges after rstb deasserts.
  - IDLE: normal operation. There is no path back to CLEAR except reset.
- Reset asserted mid-clear aborts the sequence; the sequence restarts from address 0 after deassert.
- ce or we activity during busy=1 is ignored: no write, no rvalid.
- Accepted write (ce=1, we=1, busy=0):
  - lanes with wmask[i]=1 are updated at the edge; other lanes are unchanged.
  - wmask=0 is a legal no-op write.
  - With WRITE_THROUGH=0, dout and rvalid are unaffected.
  - With WRITE_THROUGH=1, the merged post-write word follows the read pipeline with the same latency and rvalid.
- Accepted read (ce=1, we=0, busy=0):
  - the word at addr is sampled at edge N.
  - OUT_REG=0: dout and rvalid=1 are updated at edge N. OUT_REG=1: they are updated at edge N+1.
  - rvalid is high for one cycle per accepted read; back-to-back reads give back-to-back rvalid.
- Read after a write to the same address in the next cycle returns the new data. There is no read-during-write hazard because the block is single-port.
- dout retains its last value when no new data arrives. rvalid=0 otherwise.
- Addresses cover the full 2**ADDR_WIDTH space, so there is no out-of-range case.
- Elaboration check: fatal error if DATA_WIDTH % WMASK_WIDTH != 0.

Decomposition:
- Package sram22_pkg holds:
  - the FSM state enum (CLEAR, IDLE)
  - the clog2 helper
  - the MASK_GRAN derivation function
- One sub-module, sram22_clear_seq, contains the CLEAR/IDLE FSM, the address counter and busy generation. It outputs clr_en and clr_addr, which are muxed onto the array write port.
- The array, mask merge and output pipeline stay in the top module.

Test Plan:
- Defaults; release rstb at t0 -> busy=1 for exactly 64 edges, then 0; reading addr 0..63 returns 0x00000000, each with rvalid one cycle after the read.
- Write addr 5 din=0xDEADBEEF wmask=4'b1111, then write addr 5 din=0x11223344 wmask=4'b0101, then read -> dout=0xDE22BE44; with OUT_REG=1, rvalid appears 2 cycles after the read.
- ce=1 we=1 to addr 3 while busy=1 -> after the clear completes, a read of addr 3 returns 0; rvalid never pulses during busy.
- WRITE_THROUGH=1: write addr 7 din=0xA5A5A5A5 wmask=4'b0011 over existing 0xFFFFFFFF -> dout=0xFFFFA5A5 with rvalid in the write's response cycle.
- Assert rstb low at clear count 20, release -> dout=0 and rvalid=0 immediately; busy lasts a full 64 cycles again; the array reads all zero afterwards.
- CLEAR_ON_RESET=0, DATA_WIDTH=64, WMASK_WIDTH=8, ADDR_WIDTH=4 -> busy=0 from reset; three back-to-back reads give three consecutive rvalid pulses with correct words.

Source files
------------

// File: rtl/sram22_pkg.sv
// Shared types and helpers for the parametrised sram22 single-port model.
package sram22_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } sram22_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

  function automatic int unsigned mask_gran(input int unsigned data_width,
                                            input int unsigned wmask_width);
    return data_width / wmask_width;
  endfunction

endpackage

// File: rtl/sram22_clear_seq.sv
// Post-reset clear sequencer: walks every address once, holding busy until done.
module sram22_clear_seq
  import sram22_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  output logic                  busy,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  sram22_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_d;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
      busy    <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
    end
  end

  // busy drops on the same edge that writes the last address
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_en   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/sram22_param_sram.sv
// Behavioural single-port sram22 macro: masked writes, optional output register,
// optional write-through and post-reset array clear.
module sram22_param_sram
  import sram22_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned WMASK_WIDTH    = 4,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned WRITE_THROUGH  = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                    vdd,
  inout  wire                    vss,
`endif
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ce,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   rvalid,
  output logic                   busy
);

  localparam int unsigned MASK_GRAN = mask_gran(DATA_WIDTH, WMASK_WIDTH);
  localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_gran
    $fatal(1, "sram22_param_sram: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  acc_wr_c, acc_rd_c, new_vld_c;
  logic [DATA_WIDTH-1:0] rd_word_c, merged_c, new_data_c;

  sram22_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .rstb     (rstb),
    .busy     (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign acc_wr_c  = ce & we & ~busy;
  assign acc_rd_c  = ce & ~we & ~busy;
  assign rd_word_c = mem[addr];

  // lane merge of new data over the stored word
  always_comb begin
    merged_c = rd_word_c;
    for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
      if (wmask[i]) merged_c[i*MASK_GRAN +: MASK_GRAN] = din[i*MASK_GRAN +: MASK_GRAN];
    end
  end

  assign new_vld_c  = acc_rd_c | ((WRITE_THROUGH != 0) & acc_wr_c);
  assign new_data_c = acc_wr_c ? merged_c : rd_word_c;

  // array contents survive reset; only the clear sequencer zeroes them
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (acc_wr_c) begin
      mem[addr] <= merged_c;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        s1_vld  <= 1'b0;
        s1_data <= '0;
        dout    <= '0;
        rvalid  <= 1'b0;
      end else begin
        s1_vld <= new_vld_c;
        if (new_vld_c) s1_data <= new_data_c;
        rvalid <= s1_vld;
        if (s1_vld) dout <= s1_data;
      end
    end
  end else begin : g_noreg
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        dout   <= '0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= new_vld_c;
        if (new_vld_c) dout <= new_data_c;
      end
    end
  end

endmodule

// File: tb/tb_sram22_param_sram.sv
// Scoreboard bench for sram22_param_sram across three parameter sets.
module tb_sram22_param_sram;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  logic        clk, rstb;
  logic        ce, we;
  logic [3:0]  wmask;
  logic [5:0]  addr;
  logic [31:0] din;
  logic [31:0] dout0, dout1;
  logic        rv0, rv1, busy0, busy1;

  logic        ce2, we2;
  logic [7:0]  wm2;
  logic [3:0]  addr2;
  logic [63:0] din2, dout2;
  logic        rv2, busy2;

  int          cyc, clr_left, n_tests, n_fail;
  exp_t        q0[$], q1[$], q2[$];
  logic [63:0] last0, last1, last2;
  logic [31:0] mdl  [64];
  logic [63:0] mdl2 [16];

  sram22_param_sram u0 (
    .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
    .dout(dout0), .rvalid(rv0), .busy(busy0)
  );

  sram22_param_sram #(.OUT_REG(1), .WRITE_THROUGH(1)) u1 (
    .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
    .dout(dout1), .rvalid(rv1), .busy(busy1)
  );

  sram22_param_sram #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .WMASK_WIDTH(8), .CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .rstb(rstb), .ce(ce2), .we(we2), .wmask(wm2), .addr(addr2), .din(din2),
    .dout(dout2), .rvalid(rv2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one edge, then check busy and the three scoreboards
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    if (clr_left > 0) clr_left--;
    #1;
    cmp("u0_busy", 64'(busy0), 64'(clr_left > 0));
    cmp("u1_busy", 64'(busy1), 64'(clr_left > 0));
    cmp("u2_busy", 64'(busy2), 64'd0);
    if (q0.size() > 0 && q0[0].due == cyc) begin
      e = q0.pop_front();
      cmp("u0_rvalid", 64'(rv0), 64'd1);
      cmp("u0_dout", 64'(dout0), e.data);
      last0 = e.data;
    end else begin
      cmp("u0_rvalid_idle", 64'(rv0), 64'd0);
      cmp("u0_dout_hold", 64'(dout0), last0);
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      cmp("u1_rvalid", 64'(rv1), 64'd1);
      cmp("u1_dout", 64'(dout1), e.data);
      last1 = e.data;
    end else begin
      cmp("u1_rvalid_idle", 64'(rv1), 64'd0);
      cmp("u1_dout_hold", 64'(dout1), last1);
    end
    if (q2.size() > 0 && q2[0].due == cyc) begin
      e = q2.pop_front();
      cmp("u2_rvalid", 64'(rv2), 64'd1);
      cmp("u2_dout", dout2, e.data);
      last2 = e.data;
    end else begin
      cmp("u2_rvalid_idle", 64'(rv2), 64'd0);
      cmp("u2_dout_hold", dout2, last2);
    end
  endtask

  task automatic acc01(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] mg;
    logic        ok;
    ok = (clr_left == 0);
    ce = 1'b1; we = w; addr = a; din = d; wmask = m;
    mg = mdl[a];
    for (int i = 0; i < 4; i++) if (m[i]) mg[i*8 +: 8] = d[i*8 +: 8];
    if (ok) begin
      if (w) begin
        mdl[a] = mg;
        q1.push_back('{data: 64'(mg), due: cyc + 2});
      end else begin
        q0.push_back('{data: 64'(mdl[a]), due: cyc + 1});
        q1.push_back('{data: 64'(mdl[a]), due: cyc + 2});
      end
    end
    tick();
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic acc2(input logic w, input logic [3:0] a, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] mg;
    ce2 = 1'b1; we2 = w; addr2 = a; din2 = d; wm2 = m;
    mg = mdl2[a];
    for (int i = 0; i < 8; i++) if (m[i]) mg[i*8 +: 8] = d[i*8 +: 8];
    if (w) mdl2[a] = mg;
    else q2.push_back('{data: mdl2[a], due: cyc + 1});
    tick();
    ce2 = 1'b0; we2 = 1'b0;
  endtask

  task automatic reset_pulse();
    rstb = 1'b0;
    #1;
    cmp("rst_u0_dout", 64'(dout0), 64'd0);
    cmp("rst_u0_rvalid", 64'(rv0), 64'd0);
    cmp("rst_u0_busy", 64'(busy0), 64'd1);
    cmp("rst_u1_dout", 64'(dout1), 64'd0);
    cmp("rst_u1_rvalid", 64'(rv1), 64'd0);
    cmp("rst_u2_dout", dout2, 64'd0);
    cmp("rst_u2_busy", 64'(busy2), 64'd0);
    rstb = 1'b1;
    clr_left = 64;
    last0 = '0; last1 = '0; last2 = '0;
    for (int i = 0; i < 64; i++) mdl[i] = '0;
  endtask

  initial begin
    rstb = 1'b0; ce = 1'b0; we = 1'b0; wmask = '0; addr = '0; din = '0;
    ce2 = 1'b0; we2 = 1'b0; wm2 = '0; addr2 = '0; din2 = '0;
    cyc = 0; clr_left = 0; n_tests = 0; n_fail = 0;
    #12;
    reset_pulse();

    // accesses during the clear are ignored
    acc01(1'b1, 6'd3, 32'hFFFF_FFFF, 4'hF);
    acc01(1'b0, 6'd3, 32'h0, 4'h0);
    acc01(1'b1, 6'd3, 32'h1234_5678, 4'hF);

    // wide instance needs no clear: writes then back-to-back reads
    acc2(1'b1, 4'd1, 64'h0123_4567_89AB_CDEF, 8'hFF);
    acc2(1'b1, 4'd2, 64'hFEDC_BA98_7654_3210, 8'hFF);
    acc2(1'b1, 4'd3, 64'hFFFF_0000_FFFF_0000, 8'hFF);
    acc2(1'b1, 4'd3, 64'h1111_2222_3333_4444, 8'h0F);
    acc2(1'b1, 4'd15, 64'hAAAA_5555_AAAA_5555, 8'hFF);
    acc2(1'b1, 4'd2, 64'h0, 8'h00);
    acc2(1'b0, 4'd1, 64'h0, 8'h00);
    acc2(1'b0, 4'd2, 64'h0, 8'h00);
    acc2(1'b0, 4'd3, 64'h0, 8'h00);
    acc2(1'b0, 4'd15, 64'h0, 8'h00);

    while (clr_left > 0) tick();

    for (int i = 0; i < 64; i++) acc01(1'b0, 6'(i), 32'h0, 4'h0);

    acc01(1'b1, 6'd5, 32'hDEAD_BEEF, 4'b1111);
    acc01(1'b1, 6'd5, 32'h1122_3344, 4'b0101);
    acc01(1'b0, 6'd5, 32'h0, 4'h0);
    tick(); tick();

    acc01(1'b1, 6'd7, 32'hFFFF_FFFF, 4'b1111);
    acc01(1'b1, 6'd7, 32'hA5A5_A5A5, 4'b0011);
    acc01(1'b1, 6'd40, 32'hCAFE_F00D, 4'b1111);
    acc01(1'b1, 6'd63, 32'h8765_4321, 4'b1001);
    acc01(1'b0, 6'd3, 32'h0, 4'h0);
    acc01(1'b0, 6'd40, 32'h0, 4'h0);
    acc01(1'b0, 6'd63, 32'h0, 4'h0);
    acc01(1'b0, 6'd7, 32'h0, 4'h0);
    tick(); tick(); tick();

    // reset from idle with live dout, then abort a clear at count 20
    reset_pulse();
    repeat (20) tick();
    reset_pulse();
    while (clr_left > 0) tick();

    for (int i = 0; i < 64; i++) acc01(1'b0, 6'(i), 32'h0, 4'h0);
    acc2(1'b0, 4'd3, 64'h0, 8'h00);
    tick(); tick(); tick();

    cmp("q0_drained", 64'(q0.size()), 64'd0);
    cmp("q1_drained", 64'(q1.size()), 64'd0);
    cmp("q2_drained", 64'(q2.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
